// File: rtl/prime_result_buffer.sv
// rtl/prime_result_buffer.sv - show-ahead FIFO of distinct primes with running gap statistics
// Optional twin-prime counter enabled by defining PRIME_TWIN_COUNT_EN.
module prime_result_buffer #(
   parameter int WIDTH = 11,
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             prime_in,
   input  logic [WIDTH-1:0] num_in,
   input  logic             rd_en,
   output logic             rd_valid,
   output logic [WIDTH-1:0] rd_data,
   output logic [AW:0]      count,
   output logic             full,
   output logic             empty,
   output logic             overflow,
   output logic [WIDTH-1:0] last_prime,
   output logic [WIDTH-1:0] max_gap
`ifdef PRIME_TWIN_COUNT_EN
   ,output logic [WIDTH-1:0] twin_count
`endif
);

   localparam logic [AW:0] depth_c = (AW+1)'(DEPTH);
   localparam logic [AW:0] one_c   = (AW+1)'(1);
   localparam logic [AW-1:0] step_c = (AW)'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             seen_any;
   logic             cap;
   logic             pop;
   logic             push;
   logic [WIDTH-1:0] gap;

   assign empty    = (count == '0);
   assign full     = (count == depth_c);
   assign rd_valid = !empty;
   assign rd_data  = mem[rd_ptr];

   // A held prime is captured once: repeats of last_prime are filtered.
   assign cap  = in_valid & prime_in & (!seen_any | (num_in != last_prime));
   assign pop  = rd_en & rd_valid;
   assign push = cap & (!full | pop);
   assign gap  = num_in - last_prime;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= num_in;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         overflow   <= 1'b0;
         last_prime <= '0;
         max_gap    <= '0;
         seen_any   <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + step_c;
         if (pop)  rd_ptr <= rd_ptr + step_c;
         case ({push, pop})
            2'b10:   count <= count + one_c;
            2'b01:   count <= count - one_c;
            default: count <= count;
         endcase
         if (cap && full && !pop) overflow <= 1'b1;
         // Statistics follow every capture, even one dropped for lack of space.
         if (cap) begin
            last_prime <= num_in;
            seen_any   <= 1'b1;
            if (seen_any && (num_in > last_prime) && (gap > max_gap)) max_gap <= gap;
         end
      end
   end

`ifdef PRIME_TWIN_COUNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         twin_count <= '0;
      end else if (cap && seen_any && (gap == WIDTH'(2)) && (twin_count != '1)) begin
         twin_count <= twin_count + WIDTH'(1);
      end
   end
`endif

endmodule

// File: tb/tb_prime_result_buffer.sv
// tb/tb_prime_result_buffer.sv - scoreboard bench for prime_result_buffer
// Covers sweep, hold filtering, overflow, pointer wrap, sweep restart and async reset.
module tb_prime_result_buffer;

   localparam int WIDTH = 11;
   localparam int DEPTH = 16;
   localparam int AW = 4;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             prime_in;
   logic [WIDTH-1:0] num_in;
   logic             rd_en;
   logic             rd_valid;
   logic [WIDTH-1:0] rd_data;
   logic [AW:0]      count;
   logic             full;
   logic             empty;
   logic             overflow;
   logic [WIDTH-1:0] last_prime;
   logic [WIDTH-1:0] max_gap;
`ifdef PRIME_TWIN_COUNT_EN
   logic [WIDTH-1:0] twin_count;
`endif

   int total = 0;
   int bad = 0;
   logic [WIDTH-1:0] sb [$];

   prime_result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .prime_in(prime_in), .num_in(num_in),
      .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data), .count(count), .full(full),
      .empty(empty), .overflow(overflow), .last_prime(last_prime), .max_gap(max_gap)
`ifdef PRIME_TWIN_COUNT_EN
      , .twin_count(twin_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bit is_prime(input int n);
      if (n < 2) return 1'b0;
      for (int d = 2; d * d <= n; d++) if (n % d == 0) return 1'b0;
      return 1'b1;
   endfunction

   // Drives one cycle; reports head value and validity as seen at the edge.
   task automatic cycle(input logic v, input logic p, input logic [WIDTH-1:0] n, input logic r,
                        output logic pv, output logic [WIDTH-1:0] got);
      in_valid = v; prime_in = p; num_in = n; rd_en = r;
      pv = rd_valid; got = rd_data;
      @(posedge clk); #1;
      in_valid = 1'b0; prime_in = 1'b0; rd_en = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      sb.delete();
   endtask

   task automatic test_reset();
      #2;
      total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
      total++; if (empty !== 1'b1 || full !== 1'b0 || rd_valid !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b%b exp=100", empty, full, rd_valid); end
      total++; if (overflow !== 1'b0 || last_prime !== '0 || max_gap !== '0) begin bad++; $display("FAIL reset_stats got=%b/%0d/%0d exp=0/0/0", overflow, last_prime, max_gap); end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_sweep();
      logic pv; logic [WIDTH-1:0] got, exp;
      cycle(1'b0, 1'b0, '0, 1'b1, pv, got);
      total++; if (count !== 5'd0 || empty !== 1'b1) begin bad++; $display("FAIL empty_read got=%0d exp=0", count); end
      for (int n = 0; n <= 20; n++) begin
         cycle(1'b1, is_prime(n), WIDTH'(n), 1'b0, pv, got);
         if (is_prime(n)) sb.push_back(WIDTH'(n));
      end
      total++; if (count !== 5'd8) begin bad++; $display("FAIL sweep_count got=%0d exp=8", count); end
      total++; if (rd_data !== 11'd2) begin bad++; $display("FAIL sweep_head got=%0d exp=2", rd_data); end
      total++; if (last_prime !== 11'd19) begin bad++; $display("FAIL sweep_last got=%0d exp=19", last_prime); end
      total++; if (max_gap !== 11'd4) begin bad++; $display("FAIL sweep_gap got=%0d exp=4", max_gap); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL sweep_ovf got=%b exp=0", overflow); end
`ifdef PRIME_TWIN_COUNT_EN
      total++; if (twin_count !== 11'd4) begin bad++; $display("FAIL sweep_twin got=%0d exp=4", twin_count); end
`endif
      for (int i = 0; i < 8; i++) begin
         exp = sb.pop_front();
         cycle(1'b0, 1'b0, '0, 1'b1, pv, got);
         total++; if (pv !== 1'b1 || got !== exp) begin bad++; $display("FAIL sweep_pop%0d got=%0d exp=%0d", i, got, exp); end
      end
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL sweep_drained got=%b exp=1", empty); end
   endtask

   task automatic test_hold();
      logic pv; logic [WIDTH-1:0] got, exp;
      cycle(1'b1, 1'b1, 11'd5, 1'b0, pv, got); sb.push_back(11'd5);
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 11'd7, 1'b0, pv, got);
      sb.push_back(11'd7);
      total++; if (count !== 5'd2) begin bad++; $display("FAIL hold_count got=%0d exp=2", count); end
      for (int i = 0; i < 2; i++) begin
         exp = sb.pop_front();
         cycle(1'b0, 1'b0, '0, 1'b1, pv, got);
         total++; if (pv !== 1'b1 || got !== exp) begin bad++; $display("FAIL hold_pop%0d got=%0d exp=%0d", i, got, exp); end
      end
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL hold_empty got=%b exp=1", empty); end
   endtask

   task automatic test_overflow();
      logic pv; logic [WIDTH-1:0] got, exp;
      int k;
      do_reset();
      k = 0;
      for (int n = 2; n <= 59; n++) begin
         if (is_prime(n)) begin
            cycle(1'b1, 1'b1, WIDTH'(n), 1'b0, pv, got);
            if (k < DEPTH) sb.push_back(WIDTH'(n));
            k++;
         end
      end
      total++; if (full !== 1'b1 || count !== 5'd16) begin bad++; $display("FAIL ovf_full got=%b/%0d exp=1/16", full, count); end
      total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
      total++; if (rd_data !== 11'd2 || last_prime !== 11'd59) begin bad++; $display("FAIL ovf_head_last got=%0d/%0d exp=2/59", rd_data, last_prime); end
      total++; if (max_gap !== 11'd6) begin bad++; $display("FAIL ovf_gap got=%0d exp=6", max_gap); end
      exp = sb.pop_front();
      cycle(1'b1, 1'b1, 11'd61, 1'b1, pv, got);
      sb.push_back(11'd61);
      total++; if (pv !== 1'b1 || got !== exp) begin bad++; $display("FAIL ovf_pushpop got=%0d exp=%0d", got, exp); end
      total++; if (count !== 5'd16 || rd_data !== 11'd3) begin bad++; $display("FAIL ovf_after got=%0d/%0d exp=16/3", count, rd_data); end
      for (int i = 0; i < DEPTH; i++) begin
         exp = sb.pop_front();
         cycle(1'b0, 1'b0, '0, 1'b1, pv, got);
         total++; if (pv !== 1'b1 || got !== exp) begin bad++; $display("FAIL ovf_pop%0d got=%0d exp=%0d", i, got, exp); end
      end
   endtask

   task automatic test_wrap();
      logic pv; logic [WIDTH-1:0] got, exp;
      logic r;
      for (int i = 0; i < 40; i++) begin
         r = ((i % 3) != 0) && (sb.size() > 0);
         if (r) exp = sb.pop_front();
         cycle(1'b1, 1'b1, WIDTH'(100 + i), r, pv, got);
         sb.push_back(WIDTH'(100 + i));
         if (r) begin
            total++; if (pv !== 1'b1 || got !== exp) begin bad++; $display("FAIL wrap_pop%0d got=%0d exp=%0d", i, got, exp); end
         end
         total++; if (count !== (AW+1)'(sb.size())) begin bad++; $display("FAIL wrap_count%0d got=%0d exp=%0d", i, count, sb.size()); end
      end
      while (sb.size() > 0) begin
         exp = sb.pop_front();
         cycle(1'b0, 1'b0, '0, 1'b1, pv, got);
         total++; if (pv !== 1'b1 || got !== exp) begin bad++; $display("FAIL wrap_drain got=%0d exp=%0d", got, exp); end
      end
      total++; if (max_gap !== 11'd39) begin bad++; $display("FAIL wrap_gap got=%0d exp=39", max_gap); end
   endtask

   task automatic test_restart();
      logic pv; logic [WIDTH-1:0] got, exp;
      cycle(1'b1, 1'b1, 11'd97, 1'b0, pv, got); sb.push_back(11'd97);
      cycle(1'b1, 1'b1, 11'd2, 1'b0, pv, got);  sb.push_back(11'd2);
      total++; if (max_gap !== 11'd39) begin bad++; $display("FAIL restart_gap got=%0d exp=39", max_gap); end
      total++; if (last_prime !== 11'd2 || count !== 5'd2) begin bad++; $display("FAIL restart_last got=%0d/%0d exp=2/2", last_prime, count); end
      for (int i = 0; i < 2; i++) begin
         exp = sb.pop_front();
         cycle(1'b0, 1'b0, '0, 1'b1, pv, got);
         total++; if (pv !== 1'b1 || got !== exp) begin bad++; $display("FAIL restart_pop%0d got=%0d exp=%0d", i, got, exp); end
      end
   endtask

   task automatic test_async_reset();
      logic pv; logic [WIDTH-1:0] got, exp;
      for (int n = 3; n <= 13; n++) begin
         if (is_prime(n)) cycle(1'b1, 1'b1, WIDTH'(n), 1'b0, pv, got);
      end
      total++; if (count !== 5'd5) begin bad++; $display("FAIL async_pre got=%0d exp=5", count); end
      #2 rst = 1'b1;
      #1;
      total++; if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || rd_valid !== 1'b0) begin bad++; $display("FAIL async_fifo got=%0d/%b%b%b exp=0/100", count, empty, full, rd_valid); end
      total++; if (overflow !== 1'b0 || last_prime !== '0 || max_gap !== '0) begin bad++; $display("FAIL async_stats got=%b/%0d/%0d exp=0/0/0", overflow, last_prime, max_gap); end
      #2 rst = 1'b0;
      sb.delete();
      @(posedge clk); #1;
      cycle(1'b1, 1'b1, 11'd5, 1'b0, pv, got); sb.push_back(11'd5);
      total++; if (count !== 5'd1 || rd_data !== 11'd5 || last_prime !== 11'd5) begin bad++; $display("FAIL async_resume got=%0d/%0d/%0d exp=1/5/5", count, rd_data, last_prime); end
      exp = sb.pop_front();
      cycle(1'b0, 1'b0, '0, 1'b1, pv, got);
      total++; if (pv !== 1'b1 || got !== exp || empty !== 1'b1) begin bad++; $display("FAIL async_pop got=%0d exp=%0d", got, exp); end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; prime_in = 1'b0; num_in = '0; rd_en = 1'b0;
      test_reset();
      test_sweep();
      test_hold();
      test_overflow();
      test_wrap();
      test_restart();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
